// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ            = 8;   // requester count, tied to the 3-bit index
    localparam int IDX_W            = 3;   // grant index width
    localparam int MAX_HOLD_DEFAULT = 16;  // default cap on consecutive grant cycles
    localparam int HOLD_W_DEFAULT   = 8;   // default hold counter width

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first set request at or above ptr, wrapping 7->0.
// Rotates the request vector so ptr lands on bit 0, priority-encodes the lowest
// set bit, then adds ptr back to recover the absolute index.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotation: rot[k] is the requester sitting k places above ptr (mod 8).
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            assign src     = IDX_W'(gi) + ptr;
            assign rot[gi] = req[src];
        end
    endgenerate

    // Priority encoder: scan from the top so the lowest set offset wins.
    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
    end

    assign any = |req;
    assign idx = off + ptr;   // 3-bit add wraps modulo 8

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a hold-time limit.
// A grant lasts until the owner signals done, drops its request, or reaches
// MAX_HOLD cycles; every grant is followed by one idle cycle before the next.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int HOLD_W   = HOLD_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid,
    output logic             o_timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_reg,   state_next;
    logic [N_REQ-1:0]  gnt_reg,     gnt_next;
    logic [IDX_W-1:0]  idx_reg,     idx_next;
    logic              valid_reg,   valid_next;
    logic              timeout_reg, timeout_next;
    logic [IDX_W-1:0]  ptr_reg,     ptr_next;
    logic [HOLD_W-1:0] hold_reg,    hold_next;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_req;
    logic              hold_hit;
    logic              grant_end;

    rr_pick8 u_pick (
        .req (i_req),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req = i_req[idx_reg];
    assign hold_hit  = (hold_reg == HOLD_LAST);
    assign grant_end = i_done || !owner_req || hold_hit;

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            ptr_reg     <= '0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            idx_reg     <= idx_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
        end
    end

    // Next-state logic: pick a winner from IDLE, decide release in GRANT.
    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        idx_next     = idx_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next         = GRANT;
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    idx_next           = pick_idx;
                    valid_next         = 1'b1;
                    hold_next          = '0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    idx_next     = '0;
                    valid_next   = 1'b0;
                    hold_next    = '0;
                    ptr_next     = idx_reg + 1'b1;
                    // Only flag a timeout when the hold limit was the sole cause.
                    timeout_next = !i_done && owner_req;
                end else if (hold_reg != '1) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_gnt       = gnt_reg;
    assign o_gnt_idx   = idx_reg;
    assign o_gnt_valid = valid_reg;
    assign o_timeout   = timeout_reg;

    // Grant vector is one-hot or zero and always matches the index/valid pair.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(o_gnt));
    a_gnt_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        o_gnt == (o_gnt_valid ? (N_REQ'(1) << o_gnt_idx) : N_REQ'(0)));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: table-driven directed vectors, hand sequences for
// asynchronous reset, and random stimulus against a cycle-level reference model.
module tb_rr_arbiter_8;
    import rr_arb_pkg::*;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] o_gnt;
    logic [2:0] o_gnt_idx;
    logic       o_gnt_valid;
    logic       o_timeout;

    always #5 clk = ~clk;

    rr_arbiter_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_done      (done),
        .o_gnt       (o_gnt),
        .o_gnt_idx   (o_gnt_idx),
        .o_gnt_valid (o_gnt_valid),
        .o_timeout   (o_timeout)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner (-1 = nobody), next search start, cycles held so far.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    typedef struct {
        logic       rst_before;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rb, logic [7:0] r, logic d, logic [7:0] g,
                                logic [2:0] i, logic v, logic t, string tag);
        vec_t e;
        e.rst_before = rb; e.req = r; e.done = d;
        e.gnt = g; e.idx = i; e.valid = v; e.to = t; e.tag = tag;
        tbl.push_back(e);
    endfunction

    // First requester at or above p, wrapping; -1 if none.
    function automatic int search(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (p + k) % 8;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [7:0] g, logic [2:0] i, logic v, logic t);
        vectors++;
        if ({o_gnt, o_gnt_idx, o_gnt_valid, o_timeout} !== {g, i, v, t}) begin
            miscompares++;
            $display("FAIL %s @%0t: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     name, $time, o_gnt, o_gnt_idx, o_gnt_valid, o_timeout, g, i, v, t);
        end
    endtask

    task automatic check_model(string name);
        logic [7:0] g;
        logic [2:0] i;
        g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        i = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check({name, "_model"}, g, i, m_owner >= 0, m_to);
    endtask

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_step();
        int w;
        if (m_owner < 0) begin
            m_to = 1'b0;
            w = search(req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 0;
            end
        end else if (done || !req[m_owner] || (m_hold == MAX_HOLD - 1)) begin
            m_to    = !done && req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_to   = 1'b0;
            m_hold = m_hold + 1;
        end
    endtask

    task automatic tick(string name);
        model_step();
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    // Asynchronous reset taken wherever the caller is; outputs must clear at once.
    task automatic reset_now();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        reset_now();

        // Reset then idle.
        for (int k = 0; k < 5; k++) add(k == 0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "idle");
        // Single requester: three grant cycles, done, idle gap, re-grant, drop.
        add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, "single_g1");
        add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, "single_g2");
        add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, "single_g3");
        add(0, 8'h04, 1, 8'h00, 3'd0, 0, 0, "single_rel");
        add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, "single_regrant");
        add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "single_drop");
        // Round robin over all eight from ptr=0, wrapping back to 0.
        for (int k = 0; k < 9; k++) begin
            add(k == 0, 8'hFF, 0, 8'(1 << (k % 8)), 3'(k % 8), 1, 0, "rr_grant");
            add(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, "rr_rel");
        end
        // Wrap priority: grant 6 moves ptr to 7, then 7 beats 0, then 0.
        add(0, 8'h40, 0, 8'h40, 3'd6, 1, 0, "wrap_g6");
        add(0, 8'h40, 1, 8'h00, 3'd0, 0, 0, "wrap_rel6");
        add(0, 8'h81, 0, 8'h80, 3'd7, 1, 0, "wrap_g7");
        add(0, 8'h81, 1, 8'h00, 3'd0, 0, 0, "wrap_rel7");
        add(0, 8'h81, 0, 8'h01, 3'd0, 1, 0, "wrap_g0");
        add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "wrap_drop");
        // Timeout: 16 grant cycles, one pulse, re-grant; then done on cycle 16.
        for (int k = 0; k < 16; k++) add(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "to_hold");
        add(0, 8'h10, 0, 8'h00, 3'd0, 0, 1, "to_pulse");
        add(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "to_regrant");
        for (int k = 0; k < 15; k++) add(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "to_hold2");
        add(0, 8'h10, 1, 8'h00, 3'd0, 0, 0, "to_done16");
        add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "to_idle");

        foreach (tbl[n]) begin
            if (tbl[n].rst_before) reset_now();
            req  = tbl[n].req;
            done = tbl[n].done;
            tick(tbl[n].tag);
            check(tbl[n].tag, tbl[n].gnt, tbl[n].idx, tbl[n].valid, tbl[n].to);
            $display("vec %0d %s req=%h done=%b -> gnt=%h idx=%0d valid=%b to=%b",
                     n, tbl[n].tag, tbl[n].req, tbl[n].done,
                     o_gnt, o_gnt_idx, o_gnt_valid, o_timeout);
        end

        // Reset in the middle of a grant to 5; search restarts from 0 afterwards.
        req = 8'h20; done = 1'b0;
        tick("mid_grant");
        check("mid_grant_g5", 8'h20, 3'd5, 1'b1, 1'b0);
        #2;
        reset_now();
        req = 8'hFF;
        tick("post_reset");
        check("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);
        $display("seq mid_grant_reset -> gnt=%h idx=%0d", o_gnt, o_gnt_idx);
        req = 8'h00;
        tick("post_reset_drop");

        // Random stimulus against the model; requests change rarely so holds run long.
        for (int c = 0; c < 3000; c++) begin
            logic was_valid;
            was_valid = o_gnt_valid;
            if ($urandom_range(31) == 0) req = 8'($urandom);
            done = ($urandom_range(7) == 0);
            if ($urandom_range(999) == 0) reset_now();
            tick("rand");
            if (o_gnt_valid && !was_valid)
                $display("rand grant idx=%0d req=%h t=%0t", o_gnt_idx, req, $time);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
